// File: rtl/mux2_rr_arbiter.sv
// Two-master round-robin arbiter driving the 2:1 datapath mux select and a
// one-deep registered output stage, with a per-grant burst limit.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             mux_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    // state  | meaning
    // IDLE   | no grant, both readies low
    // GRANT0 | master 0 owns the datapath
    // GRANT1 | master 1 owns the datapath
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d, beat_cnt_inc;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             slot_free, fire0, fire1, fire;

    assign slot_free  = !out_valid_q || out_ready;
    assign req0_ready = (state_q == ST_GRANT0) && slot_free;
    assign req1_ready = (state_q == ST_GRANT1) && slot_free;
    assign fire0      = req0_valid && req0_ready;
    assign fire1      = req1_valid && req1_ready;
    assign fire       = fire0 || fire1;
    assign mux_sel    = (state_q == ST_GRANT1);

    // Saturates so a lone master never wraps and loses its switch point
    assign beat_cnt_inc = (fire && beat_cnt_q != MAX_CNT) ? beat_cnt_q + CW'(1) : beat_cnt_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (fire) begin
            out_data_d  = mux_sel ? req1_data : req0_data;
            out_src_d   = mux_sel;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_inc;
        case (state_q)
            ST_IDLE: begin
                beat_cnt_d = '0;
                if (req0_valid && req1_valid) begin
                    state_d = last_q ? ST_GRANT0 : ST_GRANT1;
                    last_d  = !last_q;
                end else if (req0_valid) begin
                    state_d = ST_GRANT0;
                    last_d  = 1'b0;
                end else if (req1_valid) begin
                    state_d = ST_GRANT1;
                    last_d  = 1'b1;
                end
            end
            ST_GRANT0: begin
                if (req1_valid && (!req0_valid || beat_cnt_inc == MAX_CNT)) begin
                    state_d    = ST_GRANT1;
                    last_d     = 1'b1;
                    beat_cnt_d = '0;
                end else if (!req0_valid) begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = '0;
                end
            end
            ST_GRANT1: begin
                if (req0_valid && (!req1_valid || beat_cnt_inc == MAX_CNT)) begin
                    state_d    = ST_GRANT0;
                    last_d     = 1'b0;
                    beat_cnt_d = '0;
                end else if (!req1_valid) begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
